// File: rtl/keccak_pkg.sv
// Shared constants, mode encodings and FSM state type for the SHAKE sponge control path.
package keccak_pkg;

    localparam int ROUNDS        = 24;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;

    localparam logic [1:0] MODE_SHAKE128 = 2'b00;
    localparam logic [1:0] MODE_SHAKE256 = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PERMUTE,
        WAIT_IN,
        SQUEEZE
    } sponge_ctrl_state_t;

    // Any encoding other than SHAKE256 falls back to the SHAKE128 rate.
    function automatic logic [10:0] rate_bits(input logic [1:0] mode);
        return (mode == MODE_SHAKE256) ? 11'(RATE_SHAKE256) : 11'(RATE_SHAKE128);
    endfunction

endpackage

// File: rtl/keccak_round_counter.sv
// Round index counter for one Keccak-f[1600] permutation; wraps to 0 after the last round.
module keccak_round_counter #(
    parameter int ROUNDS = keccak_pkg::ROUNDS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       en,
    output logic [4:0] round_idx,
    output logic       last_round
);

    assign last_round = (round_idx == 5'(ROUNDS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_idx <= '0;
        end else if (start) begin
            round_idx <= '0;
        end else if (en) begin
            round_idx <= last_round ? 5'd0 : round_idx + 5'd1;
        end
    end

endmodule

// File: rtl/sponge_ctrl.sv
// SHAKE sponge sequencing controller: absorb, permute, wait for input and squeeze metering.
// Optional permutation counter enabled by defining SPONGE_CTRL_PERF_EN.
module sponge_ctrl
    import keccak_pkg::*;
#(
    parameter int ROUNDS = keccak_pkg::ROUNDS,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input_buffer_ready,
    input  logic             last_block_in_buffer,
    input  logic [CNT_W-1:0] output_size,
    input  logic [1:0]       operation_mode,
    output logic             input_buffer_consumed,
    output logic             state_clear,
    output logic             absorb_en,
    output logic             round_en,
    output logic [4:0]       round_idx,
    output logic             squeeze_valid,
    input  logic             squeeze_ready,
    output logic             last_output_block,
    output logic             busy,
    output logic [31:0]      perm_count
);

    sponge_ctrl_state_t state;
    logic [CNT_W-1:0]   bits_rem;
    logic [CNT_W-1:0]   rate;
    logic [1:0]         mode;
    logic               first_blk;
    logic               last_blk;
    logic               last_round;

    assign rate = CNT_W'(rate_bits(mode));

    keccak_round_counter #(.ROUNDS(ROUNDS)) u_round_counter (
        .clk       (clk),
        .rst       (rst),
        .start     (state != PERMUTE),
        .en        (state == PERMUTE),
        .round_idx (round_idx),
        .last_round(last_round)
    );

    // Outputs are registered alongside the state they belong to, so they change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            bits_rem              <= '0;
            mode                  <= MODE_SHAKE128;
            first_blk             <= 1'b0;
            last_blk              <= 1'b0;
            input_buffer_consumed <= 1'b0;
            state_clear           <= 1'b0;
            absorb_en             <= 1'b0;
            round_en              <= 1'b0;
            squeeze_valid         <= 1'b0;
            last_output_block     <= 1'b0;
            busy                  <= 1'b0;
        end else begin
            input_buffer_consumed <= 1'b0;
            state_clear           <= 1'b0;
            absorb_en             <= 1'b0;
            round_en              <= 1'b0;
            case (state)
                IDLE: begin
                    if (input_buffer_ready) begin
                        bits_rem              <= output_size;
                        mode                  <= operation_mode;
                        first_blk             <= 1'b1;
                        state                 <= ABSORB;
                        absorb_en             <= 1'b1;
                        input_buffer_consumed <= 1'b1;
                        state_clear           <= 1'b1;
                        busy                  <= 1'b1;
                    end
                end
                ABSORB: begin
                    last_blk  <= last_block_in_buffer;
                    first_blk <= 1'b0;
                    state     <= PERMUTE;
                    round_en  <= 1'b1;
                end
                PERMUTE: begin
                    if (!last_round) begin
                        round_en <= 1'b1;
                    end else if (!last_blk) begin
                        state <= WAIT_IN;
                    end else if (bits_rem != '0) begin
                        state             <= SQUEEZE;
                        squeeze_valid     <= 1'b1;
                        last_output_block <= (bits_rem <= rate);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                WAIT_IN: begin
                    if (input_buffer_ready) begin
                        state                 <= ABSORB;
                        absorb_en             <= 1'b1;
                        input_buffer_consumed <= 1'b1;
                        state_clear           <= first_blk;
                    end
                end
                SQUEEZE: begin
                    if (squeeze_ready) begin
                        squeeze_valid     <= 1'b0;
                        last_output_block <= 1'b0;
                        if (last_output_block) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            // Not the last block, so bits_rem > rate and cannot underflow.
                            bits_rem <= bits_rem - rate;
                            state    <= PERMUTE;
                            round_en <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPONGE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perm_count <= '0;
        end else if (state == PERMUTE && last_round) begin
            perm_count <= perm_count + 32'd1;
        end
    end
`else
    assign perm_count = '0;
`endif

endmodule

// File: tb/tb_sponge_ctrl.sv
// Self-checking bench for sponge_ctrl: directed scenarios plus randomized messages against a sponge-level model.
module tb_sponge_ctrl;

    localparam int ROUNDS = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        input_buffer_ready;
    logic        last_block_in_buffer;
    logic [31:0] output_size;
    logic [1:0]  operation_mode;
    logic        input_buffer_consumed;
    logic        state_clear;
    logic        absorb_en;
    logic        round_en;
    logic [4:0]  round_idx;
    logic        squeeze_valid;
    logic        squeeze_ready;
    logic        last_output_block;
    logic        busy;
    logic [31:0] perm_count;

    sponge_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .input_buffer_ready   (input_buffer_ready),
        .last_block_in_buffer (last_block_in_buffer),
        .output_size          (output_size),
        .operation_mode       (operation_mode),
        .input_buffer_consumed(input_buffer_consumed),
        .state_clear          (state_clear),
        .absorb_en            (absorb_en),
        .round_en             (round_en),
        .round_idx            (round_idx),
        .squeeze_valid        (squeeze_valid),
        .squeeze_ready        (squeeze_ready),
        .last_output_block    (last_output_block),
        .busy                 (busy),
        .perm_count           (perm_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int total_perms = 0;

    // Monitor observations for the message in flight
    bit   rec = 1'b0;
    int   abs_cyc[$];
    bit   last_q[$];
    int   n_clear, clear_bad, cons_bad, n_round, first_round_cyc, idx_bad, run_bad, run_pos;
    int   n_sq, first_sv_cyc, hs_cyc, drop_bad, busy_bad, cur_wait, max_wait;
    logic [31:0] sq_perm;
    logic prev_sv, prev_sr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_perm(input int n);
`ifdef SPONGE_CTRL_PERF_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    function automatic int model_rate(input logic [1:0] mode);
        return (mode == 2'b01) ? 1088 : 1344;
    endfunction

    task automatic mon_clear();
        abs_cyc.delete();
        last_q.delete();
        n_clear = 0; clear_bad = 0; cons_bad = 0; n_round = 0; first_round_cyc = -1;
        idx_bad = 0; run_bad = 0; run_pos = 0; n_sq = 0; first_sv_cyc = -1; hs_cyc = -1;
        drop_bad = 0; busy_bad = 0; cur_wait = 0; max_wait = 0; sq_perm = '0;
        prev_sv = 1'b0; prev_sr = 1'b0;
    endtask

    task automatic mon_step();
        if (absorb_en) begin
            abs_cyc.push_back(cyc);
            if (state_clear) begin
                n_clear++;
                if (abs_cyc.size() != 1) clear_bad++;
            end
        end else if (state_clear) begin
            clear_bad++;
        end
        if (input_buffer_consumed !== absorb_en) cons_bad++;
        if (round_en) begin
            if (first_round_cyc < 0) first_round_cyc = cyc;
            if (round_idx !== 5'(run_pos)) idx_bad++;
            run_pos++;
            n_round++;
        end else begin
            if (run_pos != 0 && run_pos != ROUNDS) run_bad++;
            run_pos = 0;
        end
        if (squeeze_valid) begin
            if (first_sv_cyc < 0) first_sv_cyc = cyc;
            if (squeeze_ready) begin
                last_q.push_back(last_output_block);
                if (n_sq == 0) sq_perm = perm_count;
                n_sq++;
                hs_cyc   = cyc;
                cur_wait = 0;
            end else begin
                cur_wait++;
                if (cur_wait > max_wait) max_wait = cur_wait;
            end
        end else if (last_output_block) begin
            drop_bad++;
        end
        if (prev_sv && !prev_sr && !squeeze_valid) drop_bad++;
        if ((absorb_en || round_en || squeeze_valid) && !busy) busy_bad++;
        prev_sv = squeeze_valid;
        prev_sr = squeeze_ready;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rec) mon_step();
    end

    // Drives one message through the DUT and checks it against the sponge-level expectations.
    task automatic run_msg(input string name, input logic [1:0] mode, input int size, input int nblk,
                           input int max_gap, input int stall_fix, input bit rand_stall);
        int  rate, nsq, perms, idx, gap, t0, end_cyc, sv_wait, limit, flag_bad;
        bit  pending, done;
        rate  = model_rate(mode);
        nsq   = (size == 0) ? 0 : (size + rate - 1) / rate;
        perms = nblk + ((nsq > 0) ? nsq - 1 : 0);
        idx = 0; gap = 0; t0 = -1; end_cyc = -1; sv_wait = 0; limit = 0;
        pending = 1'b0; done = 1'b0;
        mon_clear();
        operation_mode = mode;
        output_size    = 32'(size);
        rec = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (input_buffer_consumed) begin
                idx++;
                pending = 1'b0;
                gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            end else if (!pending) begin
                if (idx < nblk && gap == 0) begin
                    input_buffer_ready   = 1'b1;
                    last_block_in_buffer = (idx == nblk - 1);
                    pending = 1'b1;
                    if (t0 < 0) t0 = cyc;
                end else begin
                    input_buffer_ready   = 1'b0;
                    last_block_in_buffer = ($urandom_range(0, 1) == 1);
                    if (gap > 0) gap--;
                end
            end
            if (squeeze_valid) begin
                if (sv_wait == 0) limit = rand_stall ? int'($urandom_range(0, 3)) : stall_fix;
                squeeze_ready = (sv_wait >= limit);
                sv_wait++;
            end else begin
                squeeze_ready = rand_stall ? ($urandom_range(0, 1) == 1) : 1'b0;
                sv_wait = 0;
            end
            if (idx == nblk && !busy) begin
                end_cyc = cyc;
                done = 1'b1;
                break;
            end
        end
        @(negedge clk);
        rec = 1'b0;
        input_buffer_ready = 1'b0;
        squeeze_ready      = 1'b0;
        total_perms += perms;

        check({name, ".done"}, 64'(done), 64'd1);
        check({name, ".absorbs"}, 64'(abs_cyc.size()), 64'(nblk));
        check({name, ".clears"}, 64'(n_clear), 64'd1);
        check({name, ".clear_bad"}, 64'(clear_bad), 64'd0);
        check({name, ".consumed_bad"}, 64'(cons_bad), 64'd0);
        check({name, ".round_cycles"}, 64'(n_round), 64'(ROUNDS * perms));
        check({name, ".round_idx_bad"}, 64'(idx_bad), 64'd0);
        check({name, ".round_run_bad"}, 64'(run_bad), 64'd0);
        check({name, ".squeeze_blocks"}, 64'(n_sq), 64'(nsq));
        check({name, ".drop_bad"}, 64'(drop_bad), 64'd0);
        check({name, ".busy_bad"}, 64'(busy_bad), 64'd0);
        flag_bad = 0;
        foreach (last_q[i]) if (last_q[i] != (i == nsq - 1)) flag_bad++;
        check({name, ".last_flag_bad"}, 64'(flag_bad), 64'd0);
        if (nsq > 0) begin
            check({name, ".perm_at_squeeze"}, 64'(sq_perm), 64'(exp_perm(total_perms - perms + nblk)));
            check({name, ".idle_after_handshake"}, 64'(end_cyc), 64'(hs_cyc + 1));
        end
        if (max_gap == 0 && abs_cyc.size() == nblk) begin
            check({name, ".first_absorb_cyc"}, 64'(abs_cyc[0]), 64'(t0 + 1));
            check({name, ".first_round_cyc"}, 64'(first_round_cyc), 64'(t0 + 2));
            for (int k = 1; k < nblk; k++)
                check({name, ".absorb_spacing"}, 64'(abs_cyc[k] - abs_cyc[k-1]), 64'(ROUNDS + 2));
            if (nsq > 0)
                check({name, ".first_sv_cyc"}, 64'(first_sv_cyc), 64'(t0 + (ROUNDS + 2) * nblk));
        end
        check({name, ".perm_count"}, 64'(perm_count), 64'(exp_perm(total_perms)));
        check({name, ".busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int sz, nb, sel;
        logic [1:0] md;
        rst = 1'b1;
        input_buffer_ready = 1'b0;
        last_block_in_buffer = 1'b0;
        output_size = '0;
        operation_mode = 2'b00;
        squeeze_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({input_buffer_consumed, state_clear, absorb_en, round_en, round_idx,
                                    squeeze_valid, last_output_block, busy, perm_count}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_outputs", 64'({input_buffer_consumed, state_clear, absorb_en, round_en, round_idx,
                                   squeeze_valid, last_output_block, busy, perm_count}), 64'd0);

        run_msg("shake128_single", 2'b00, 256, 1, 0, 0, 1'b0);
        run_msg("shake256_three_blocks", 2'b01, 512, 3, 0, 0, 1'b0);
        run_msg("shake128_3000", 2'b00, 3000, 1, 0, 0, 1'b0);
        run_msg("squeeze_stall", 2'b00, 256, 1, 0, 10, 1'b0);
        check("squeeze_stall.max_wait", 64'(max_wait), 64'd10);
        run_msg("size_zero", 2'b00, 0, 2, 0, 0, 1'b0);
        run_msg("exact_rate", 2'b01, 1088, 1, 0, 0, 1'b0);

        // Reset in the middle of a permutation
        operation_mode = 2'b00;
        output_size = 32'd256;
        last_block_in_buffer = 1'b1;
        input_buffer_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            input_buffer_ready = 1'b0;
            if (round_en && round_idx == 5'd12) break;
        end
        check("pre_reset_round_idx", 64'(round_idx), 64'd12);
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", 64'({input_buffer_consumed, state_clear, absorb_en, round_en, round_idx,
                                        squeeze_valid, last_output_block, busy, perm_count}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        total_perms = 0;
        run_msg("after_reset", 2'b00, 256, 1, 0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            md  = 2'($urandom_range(0, 3));
            nb  = int'($urandom_range(1, 3));
            sel = int'($urandom_range(0, 3));
            sz  = (sel == 0) ? model_rate(md) * int'($urandom_range(1, 3)) :
                  (sel == 1) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 5000));
            run_msg($sformatf("random%0d", r), md, sz, nb, 3, 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
